// File: rtl/status_ctrl.sv
// Architectural status word: ALU flags, imask, mode; interrupt entry/return sequencing.
// Optional nesting (4-deep save stack) enabled by defining STATUS_CTRL_NEST_EN.
package reg_pkg;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_status_t;

  typedef struct packed {
    alu_status_t flags;
    logic        imask;
    logic        mode;   // 0 = kernel, 1 = user
  } status_t;
endpackage

module status_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  input  reg_pkg::alu_status_t alu_status_in,
  input  logic                 alu_status_we,
  input  reg_pkg::status_t     status_in,
  input  logic                 status_we,
  input  logic                 irq,
  input  logic                 boundary,
  input  logic                 rti,
  output reg_pkg::status_t     status_out,
  output logic                 int_pending,
  output logic                 int_enter,
  output logic                 priv_fault
);
  import reg_pkg::*;

`ifdef STATUS_CTRL_NEST_EN
  localparam int MAX = 4;
  localparam int DW  = 3;
`else
  localparam int MAX = 1;
  localparam int DW  = 1;
`endif

  localparam logic MODE_KERNEL = 1'b0;

  status_t       status;
  logic          irq_q;
  logic          pending;
  logic          enter_q;
  logic          fault_q;
  logic [DW-1:0] depth;

  logic    irq_rise;
  logic    rti_ok;
  logic    take;
  status_t save_val;
  status_t restore_val;

`ifdef STATUS_CTRL_NEST_EN
  status_t   stack [4];
  logic [1:0] sp_rd;
  assign sp_rd       = depth[1:0] - 2'd1;
  assign restore_val = stack[sp_rd];
`else
  status_t stack;
  assign restore_val = stack;
`endif

  assign irq_rise = irq & ~irq_q;
  assign rti_ok   = (status.mode == MODE_KERNEL) && (depth != '0);
  assign take     = pending && !status.imask && boundary && (depth < DW'(MAX)) && !rti;
  // An ALU result retiring on the entry cycle belongs to the interrupted context.
  assign save_val = {(alu_status_we ? alu_status_in : status.flags), status.imask, status.mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      status  <= '{flags: '0, imask: 1'b1, mode: MODE_KERNEL};
      irq_q   <= 1'b0;
      pending <= 1'b0;
      enter_q <= 1'b0;
      fault_q <= 1'b0;
      depth   <= '0;
`ifdef STATUS_CTRL_NEST_EN
      for (int i = 0; i < 4; i++) stack[i] <= '0;
`else
      stack <= '0;
`endif
    end else begin
      irq_q   <= irq;
      enter_q <= take;
      fault_q <= 1'b0;
      // A fresh edge on the entry cycle is a new request and must not be lost.
      if (irq_rise)  pending <= 1'b1;
      else if (take) pending <= 1'b0;

      if (rti) begin
        if (rti_ok) begin
          status <= restore_val;
          depth  <= depth - DW'(1);
        end else begin
          fault_q <= 1'b1;
        end
      end else if (take) begin
`ifdef STATUS_CTRL_NEST_EN
        stack[depth[1:0]] <= save_val;
`else
        stack <= save_val;
`endif
        status <= '{flags: save_val.flags, imask: 1'b1, mode: MODE_KERNEL};
        depth  <= depth + DW'(1);
      end else if (status_we) begin
        if (status.mode == MODE_KERNEL) begin
          status <= status_in;
        end else begin
          status.flags <= status_in.flags;
          fault_q      <= (status_in.imask != status.imask) || (status_in.mode != status.mode);
        end
      end else if (alu_status_we) begin
        status.flags <= alu_status_in;
      end
    end
  end

  assign status_out  = status;
  assign int_pending = pending;
  assign int_enter   = enter_q;
  assign priv_fault  = fault_q;
endmodule

// File: tb/tb_status_ctrl.sv
// Directed + random bench for status_ctrl; reference model keeps saved contexts in a queue.
module tb_status_ctrl;
`ifdef STATUS_CTRL_NEST_EN
  localparam int MAX = 4;
`else
  localparam int MAX = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] alu_status_in;
  logic       alu_status_we;
  logic [5:0] status_in;
  logic       status_we;
  logic       irq;
  logic       boundary;
  logic       rti;
  logic [5:0] status_out;
  logic       int_pending;
  logic       int_enter;
  logic       priv_fault;

  status_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_status_in(alu_status_in), .alu_status_we(alu_status_we),
    .status_in(status_in), .status_we(status_we),
    .irq(irq), .boundary(boundary), .rti(rti),
    .status_out(status_out), .int_pending(int_pending),
    .int_enter(int_enter), .priv_fault(priv_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [5:0] m_status;
  logic       m_irq_q, m_pending, m_enter, m_fault;
  logic [5:0] m_stack[$];

  task automatic chk(string tag, logic [5:0] got, logic [5:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic       edge_seen, entry;
    logic [5:0] sv;
    edge_seen = irq && !m_irq_q;
    m_enter = 1'b0;
    m_fault = 1'b0;
    if (rst) begin
      m_status = 6'b000010; m_irq_q = 1'b0; m_pending = 1'b0; m_stack.delete();
    end else begin
      entry = m_pending && !m_status[1] && boundary && (m_stack.size() < MAX) && !rti;
      if (rti) begin
        if (m_status[0] == 1'b0 && m_stack.size() > 0) m_status = m_stack.pop_back();
        else m_fault = 1'b1;
      end else if (entry) begin
        sv = {(alu_status_we ? alu_status_in : m_status[5:2]), m_status[1:0]};
        m_stack.push_back(sv);
        m_status = {sv[5:2], 2'b10};
        m_enter = 1'b1;
      end else if (status_we) begin
        if (m_status[0] == 1'b0) m_status = status_in;
        else begin
          if (status_in[1:0] != m_status[1:0]) m_fault = 1'b1;
          m_status[5:2] = status_in[5:2];
        end
      end else if (alu_status_we) begin
        m_status[5:2] = alu_status_in;
      end
      if (edge_seen)  m_pending = 1'b1;
      else if (entry) m_pending = 1'b0;
      m_irq_q = irq;
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".status"},  status_out,         m_status);
    chk({tag, ".pending"}, 6'(int_pending),    6'(m_pending));
    chk({tag, ".enter"},   6'(int_enter),      6'(m_enter));
    chk({tag, ".fault"},   6'(priv_fault),     6'(m_fault));
  endtask

  task automatic drv(string tag, logic r, logic i, logic b, logic t,
                     logic sw, logic [5:0] si, logic aw, logic [3:0] ai);
    rst = r; irq = i; boundary = b; rti = t;
    status_we = sw; status_in = si; alu_status_we = aw; alu_status_in = ai;
    tick(tag);
  endtask

  initial begin
    m_status = 6'b000010; m_irq_q = 0; m_pending = 0; m_enter = 0; m_fault = 0;

    // reset and idle; irq edge while masked only pends
    drv("rst0", 1, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("rst1", 1, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    chk("reset_status", status_out, 6'b000010);
    chk("reset_pulses", {3'b0, int_pending, int_enter, priv_fault}, 6'b0);
    drv("idle", 0, 0, 1, 0, 0, 6'h00, 0, 4'h0);
    drv("irq_masked", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    chk("masked_pending", 6'(int_pending), 6'd1);
    drv("masked_hold", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    chk("masked_no_enter", 6'(int_enter), 6'd0);

    // kernel write to user/unmasked, then entry and return
    drv("kwrite", 0, 1, 0, 0, 1, 6'b000001, 0, 4'h0);
    chk("kwrite_val", status_out, 6'b000001);
    drv("entry", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    chk("entry_status", status_out, 6'b000010);
    chk("entry_pulse", {4'b0, int_enter, int_pending}, 6'b000010);
    drv("post_entry", 0, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    chk("enter_one_cycle", 6'(int_enter), 6'd0);
    drv("rti1", 0, 0, 0, 1, 0, 6'h00, 0, 4'h0);
    chk("rti1_restore", status_out, 6'b000001);

    // user-mode write attempting kernel/mask change, user rti
    drv("uwrite", 0, 0, 0, 0, 1, 6'b101000, 0, 4'h0);
    chk("uwrite_val", status_out, 6'b101001);
    chk("uwrite_fault", 6'(priv_fault), 6'd1);
    drv("uwrite_after", 0, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("urti", 0, 0, 0, 1, 0, 6'h00, 0, 4'h0);
    chk("urti_fault", {priv_fault, status_out[4:0]}, {1'b1, 5'b01001});

    // ALU flags merged into saved context on entry cycle
    drv("irq_up2", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("entry_alu", 0, 1, 1, 0, 1, 6'b111111, 1, 4'b0110);
    drv("rti2", 0, 0, 0, 1, 0, 6'h00, 0, 4'h0);
    chk("merged_flags", 6'(status_out[5:2]), 6'b000110);

    // kernel rti at depth 0, reset mid-handler
    drv("rst2", 1, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("krti0", 0, 0, 0, 1, 0, 6'h00, 0, 4'h0);
    chk("krti0_fault", {priv_fault, status_out[4:0]}, {1'b1, 5'b00010});
    drv("kwrite3", 0, 0, 0, 0, 1, 6'b000001, 0, 4'h0);
    drv("irq_up3", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("entry3", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    drv("irq_up3b", 0, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("irq_up3c", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("rst_mid", 1, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    chk("rst_mid_vals", {status_out[5:1], int_pending}, 6'b000010);
    drv("rti_after_rst", 0, 1, 0, 1, 0, 6'h00, 0, 4'h0);
    chk("rti_after_rst_fault", 6'(priv_fault), 6'd1);

    // nesting limit
    drv("nest_kw", 0, 0, 0, 0, 1, 6'b000000, 0, 4'h0);
`ifdef STATUS_CTRL_NEST_EN
    for (int k = 0; k < 4; k++) begin
      drv("nest_lo", 0, 0, 0, 0, 0, 6'h00, 0, 4'h0);
      drv("nest_hi", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
      drv("nest_ent", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
      drv("nest_unmask", 0, 1, 0, 0, 1, {4'(k + 1), 2'b00}, 0, 4'h0);
    end
    drv("fifth_lo", 0, 0, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("fifth_hi", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    for (int k = 0; k < 3; k++) drv("fifth_blk", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    chk("fifth_pending", {int_pending, int_enter}, 2'b10);
    for (int j = 0; j < 4; j++) begin
      drv("lifo_rti", 0, 1, 0, 1, 0, 6'h00, 0, 4'h0);
      chk("lifo_order", status_out, {4'(3 - j), 2'b00});
    end
`else
    drv("nest_hi", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    drv("nest_ent", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    drv("nest_unmask", 0, 0, 0, 0, 1, 6'b010100, 0, 4'h0);
    drv("second_hi", 0, 1, 0, 0, 0, 6'h00, 0, 4'h0);
    for (int k = 0; k < 3; k++) drv("second_blk", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    chk("second_pending", {int_pending, int_enter}, 2'b10);
    drv("second_rti", 0, 1, 0, 1, 0, 6'h00, 0, 4'h0);
    chk("second_rti_val", status_out, 6'b000000);
    drv("second_ent", 0, 1, 1, 0, 0, 6'h00, 0, 4'h0);
    chk("second_taken", {int_pending, int_enter}, 2'b01);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drv("rand",
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) == 0) ? ~irq : irq,
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 4) == 0),
          6'($urandom),
          ($urandom_range(0, 2) == 0),
          4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
